// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet output-stage constants and argmax state encoding
package lenet_pkg;

  localparam int N_CLASS = 10;
  localparam int DW      = 18;
  localparam int IDXW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/layer6_argmax.sv
// rtl/layer6_argmax.sv - sequential argmax over the FC-layer class scores
module layer6_argmax #(
  parameter int N_CLASS = lenet_pkg::N_CLASS,
  parameter int DW      = lenet_pkg::DW,
  parameter int IDXW    = lenet_pkg::IDXW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fc_finish,
  input  logic [N_CLASS*DW-1:0]   din,
  output logic                    busy,
  output logic                    done,
  output logic [IDXW-1:0]         class_id,
  output logic signed [DW-1:0]    max_val
);

  import lenet_pkg::*;

  argmax_state_t        r_state;
  argmax_state_t        w_state_nxt;
  logic                 r_fc_prev;
  logic signed [DW-1:0] r_bank [N_CLASS];
  logic signed [DW-1:0] r_best_val;
  logic [IDXW-1:0]      r_best_idx;
  logic [IDXW-1:0]      r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic [IDXW-1:0]      r_class_id;
  logic signed [DW-1:0] r_max_val;

  logic                 w_start;
  logic                 w_last;
  logic                 w_gt;
  logic signed [DW-1:0] w_cur;

  // A new classification needs a fresh low-to-high fc_finish while idle;
  // a level held high or edges during a run never start another one.
  assign w_start = (r_state == IDLE) && fc_finish && !r_fc_prev;
  assign w_last  = (r_idx == IDXW'(N_CLASS - 1));
  assign w_cur   = r_bank[r_idx];
  // Strict compare so an equal later score never displaces the earlier index.
  assign w_gt    = (w_cur > r_best_val);

  assign busy     = r_busy;
  assign done     = r_done;
  assign class_id = r_class_id;
  assign max_val  = r_max_val;

  // Previous fc_finish sample for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fc_prev <= 1'b0;
    end else begin
      r_fc_prev <= fc_finish;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: one scan step per cycle, single DONE cycle, back to idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SCAN;
      SCAN:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Score bank capture at the start edge, then one comparison per SCAN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CLASS; i++) begin
        r_bank[i] <= '0;
      end
      r_best_val <= '0;
      r_best_idx <= '0;
      r_idx      <= '0;
    end else if (w_start) begin
      for (int i = 0; i < N_CLASS; i++) begin
        r_bank[i] <= din[(N_CLASS-1-i)*DW +: DW];
      end
      r_best_val <= din[N_CLASS*DW-1 -: DW];
      r_best_idx <= '0;
      r_idx      <= IDXW'(1);
    end else if (r_state == SCAN) begin
      if (w_gt) begin
        r_best_val <= w_cur;
        r_best_idx <= r_idx;
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  // Registered status and result outputs; results only move in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_class_id <= '0;
      r_max_val  <= '0;
    end else begin
      r_busy <= (r_state != IDLE);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_class_id <= r_best_idx;
        r_max_val  <= r_best_val;
      end
    end
  end

endmodule

// File: doc/layer6_argmax.md
LAYER6_ARGMAX -- requirements
Module: layer6_argmax

Interface
REQ-001 Parameter: N_CLASS, 10, number of class scores.
REQ-002 Parameter: DW, 18, signed width of each score.
REQ-003 Parameter: IDXW, 4, width of the class index, ceil(log2(N_CLASS)).
REQ-004 Port: clk, input, 1, single clock; all logic on the rising edge.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: fc_finish, input, 1, FC-layer completion flag; level or pulse.
REQ-007 Port: din, input, N_CLASS*DW (180), packed scores; score 0 in bits [179:162] and score 9 in bits [17:0].
REQ-008 Port: busy, output, 1, high while a classification is in progress.
REQ-009 Port: done, output, 1, one-cycle pulse when class_id and max_val are updated.
REQ-010 Port: class_id, output, IDXW, index of the maximum score.
REQ-011 Port: max_val, output, DW, signed value of the maximum score.

Function
REQ-012 Start condition: a rising edge of fc_finish, meaning fc_finish sampled 1 with the previous sample 0, while the state is IDLE.
REQ-013 States are IDLE, SCAN and DONE.
- IDLE -> SCAN on the start condition.
- SCAN -> DONE after comparing index N_CLASS-1.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 At the start edge (call it T), the block shall:
- capture all N_CLASS scores from din into an internal register bank;
- load best_val = score0 and best_idx = 0;
- load idx = 1.
REQ-015 In SCAN, one comparison per cycle: if score[idx] > best_val (signed, strict), update best_val and best_idx; then increment idx.
REQ-016 Ties resolve to the lowest index; an equal score never replaces the current best.
REQ-017 On the DONE edge (T+10), the block shall register best_idx into class_id and best_val into max_val, and drive done=1 for exactly one cycle.
REQ-018 Latency from start edge T to done high is exactly N_CLASS clocks (10), fixed and data-independent.
REQ-019 busy is 1 from T+1 through the cycle in which done is 1, and 0 otherwise.
REQ-020 din is sampled only at edge T; changes to din afterwards do not affect the result.
REQ-021 fc_finish edges while busy are ignored and not queued.
- A level still high after DONE does not retrigger; a new low-to-high transition is required.
REQ-022 class_id and max_val hold their last values between classifications; they change only on the DONE edge.
REQ-023 Comparisons use full DW-bit signed arithmetic with no truncation or saturation.
- Most-negative value 0x20000 is handled correctly.

Reset
REQ-024 While reset=0, the block shall asynchronously force:
- state to IDLE;
- busy, done, class_id and max_val to 0;
- the internal index to 0 and the score bank to 0;
- the fc_finish edge-detect register to 0.
REQ-025 Reset asserted mid-SCAN aborts the classification with no done pulse; outputs read 0 after reset.
REQ-026 After reset release, fc_finish already high counts as a rising edge on the first sampled clock, because the previous sample is 0.

Structure
REQ-027 Shared package lenet_pkg shall hold N_CLASS, DW, IDXW and the state enumeration (IDLE, SCAN, DONE), for reuse by the FC and output stages.
REQ-028 No sub-module is required. Edge detection, the score bank, the comparator and the FSM shall be implemented in this module; the score bank is addressed by idx.

Verification
REQ-029 Scores 0..9 = {5,3,9,1,0,2,8,7,6,4}, fc_finish pulse -> done exactly 10 clocks later, class_id=2, max_val=9, busy high for 10 cycles.
REQ-030 All scores = -100 (0x3FF9C) -> class_id=0, max_val=-100 (tie resolves to the lowest index).
REQ-031 score9 = 131071 (0x1FFFF) and all others = -131072 (0x20000) -> class_id=9, max_val=131071 (signed extremes).
REQ-032 Second fc_finish edge at T+4, with din changed to make index 7 largest -> result is still from the data captured at T; a single done pulse; no second run.
REQ-033 Reset asserted at T+5 and released 2 cycles later -> no done pulse, outputs 0, state IDLE; a new edge afterwards gives a correct result after 10 clocks.
REQ-034 fc_finish held high for 30 cycles -> exactly one done pulse; after it drops and rises again, a second done follows 10 clocks after the new edge.
